// File: rtl/fpadd_pkg.sv
// Shared types and constants for the FP32 adder pipeline.
// Holds the operand struct, alignment-state enum and counter helper.
package fpadd_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;
  localparam int SIG_W = 24;
  localparam int EXT_W = 8;
  localparam int ALN_W = SIG_W + EXT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ADD,
    S_DONE
  } align_state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] x
  );
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

endpackage

// File: rtl/fp_align_stage_if.sv
// Operand/result bundle between the align stage and its neighbours.
// master: the upstream/normalizer side; slave: the align stage.
interface fp_align_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alignedResult;
  logic        carryOut;
  logic        sticky;
  logic [7:0]  exponentOut;
  logic        alignedSign;
  logic        ANaN, BNaN;
  logic        Ainf, Binf;
  logic        Azero, Bzero;
  logic        Asub, Bsub;
  logic        bypassALU;
  logic        Aex, Bex;
  logic [31:0] A_q;
  logic [31:0] B_q;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid,
    input  alignedResult, carryOut, sticky,
    input  exponentOut, alignedSign,
    input  ANaN, BNaN, Ainf, Binf,
    input  Azero, Bzero, Asub, Bsub,
    input  bypassALU, Aex, Bex, A_q, B_q
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid,
    output alignedResult, carryOut, sticky,
    output exponentOut, alignedSign,
    output ANaN, BNaN, Ainf, Binf,
    output Azero, Bzero, Asub, Bsub,
    output bypassALU, Aex, Bex, A_q, B_q
  );
endinterface

// File: rtl/fp_classify.sv
// Per-operand IEEE-754 single classification.
// Subnormals get effective exponent 1 and no hidden bit.
import fpadd_pkg::*;

module fp_classify (
  input  logic [7:0]  exp_i,
  input  logic [22:0] man_i,
  output logic        nan_o,
  output logic        inf_o,
  output logic        zero_o,
  output logic        sub_o,
  output logic        hid_o,
  output logic [7:0]  eexp_o
);

  logic exp_max;
  logic exp_min;
  logic man_nz;

  always_comb begin
    exp_max = (exp_i == EXP_ALL_ONES);
    exp_min = (exp_i == 8'h00);
    man_nz  = |man_i;
    nan_o   = exp_max & man_nz;
    inf_o   = exp_max & ~man_nz;
    zero_o  = exp_min & ~man_nz;
    sub_o   = exp_min & man_nz;
    hid_o   = ~exp_min;
    eexp_o  = exp_min ? 8'd1 : exp_i;
  end

endmodule

// File: rtl/fp_align_stage.sv
// FP32 adder align/add stage: order, shift-with-sticky, add/sub.
// FP_ALIGN_STATS_EN adds saturating op/bypass/shift-cycle counters.
import fpadd_pkg::*;

module fp_align_stage #(
  parameter int SHIFT_PER_CYCLE = 4,
  parameter int BYPASS_DIFF     = 26
) (
  input  logic         clk,
  input  logic         rst,
  fp_align_if.slave    io
`ifdef FP_ALIGN_STATS_EN
  ,
  output logic [31:0]  stat_ops,
  output logic [31:0]  stat_bypass,
  output logic [31:0]  stat_shift_cycles
`endif
);

  localparam logic [7:0] SPC =
    8'(SHIFT_PER_CYCLE);

  fp32_t fa, fb;
  assign fa = io.A;
  assign fb = io.B;

  logic a_nan, a_inf, a_zero, a_sub, a_hid;
  logic b_nan, b_inf, b_zero, b_sub, b_hid;
  logic [7:0] a_ee, b_ee;

  fp_classify u_cls_a (
    .exp_i  (fa.exp),
    .man_i  (fa.mant),
    .nan_o  (a_nan),
    .inf_o  (a_inf),
    .zero_o (a_zero),
    .sub_o  (a_sub),
    .hid_o  (a_hid),
    .eexp_o (a_ee)
  );

  fp_classify u_cls_b (
    .exp_i  (fb.exp),
    .man_i  (fb.mant),
    .nan_o  (b_nan),
    .inf_o  (b_inf),
    .zero_o (b_zero),
    .sub_o  (b_sub),
    .hid_o  (b_hid),
    .eexp_o (b_ee)
  );

  align_state_t state_q, state_d;
  logic [ALN_W-1:0] big_q, big_d;
  logic [ALN_W-1:0] sml_q, sml_d;
  logic        acc_q, acc_d;
  logic [7:0]  rem_q, rem_d;
  logic        bsgn_q, bsgn_d;
  logic        esub_q, esub_d;
  logic [7:0]  bexp_q, bexp_d;
  logic [31:0] res_q, res_d;
  logic        carry_q, carry_d;
  logic        stk_q, stk_d;
  logic        sgn_q, sgn_d;
  logic [7:0]  expo_q, expo_d;
  logic [7:0]  flg_q, flg_d;
  logic        byp_q, byp_d;
  logic        aex_q, aex_d;
  logic        bex_q, bex_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;

  logic        a_big;
  logic        big_h, sml_h;
  logic [22:0] big_m, sml_m;
  logic [7:0]  big_ee, sml_ee;
  logic [7:0]  diff;
  logic        special;
  logic        far;
  logic [7:0]  step;
  logic [31:0] mask;
  logic [32:0] sum;
  logic [31:0] dif;

  always_comb begin
    state_d = state_q;
    big_d   = big_q;
    sml_d   = sml_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    bsgn_d  = bsgn_q;
    esub_d  = esub_q;
    bexp_d  = bexp_q;
    res_d   = res_q;
    carry_d = carry_q;
    stk_d   = stk_q;
    sgn_d   = sgn_q;
    expo_d  = expo_q;
    flg_d   = flg_q;
    byp_d   = byp_q;
    aex_d   = aex_q;
    bex_d   = bex_q;
    a_d     = a_q;
    b_d     = b_q;

    a_big  = {fa.exp, fa.mant} >=
             {fb.exp, fb.mant};
    big_h  = a_big ? a_hid : b_hid;
    sml_h  = a_big ? b_hid : a_hid;
    big_m  = a_big ? fa.mant : fb.mant;
    sml_m  = a_big ? fb.mant : fa.mant;
    big_ee = a_big ? a_ee : b_ee;
    sml_ee = a_big ? b_ee : a_ee;
    diff   = big_ee - sml_ee;
    special = |{a_nan, a_inf, a_zero,
                b_nan, b_inf, b_zero};
    far    = int'(diff) >= BYPASS_DIFF;

    step = (rem_q > SPC) ? SPC : rem_q;
    mask = (32'd1 << step) - 32'd1;
    sum  = {1'b0, big_q} + {1'b0, sml_q};
    dif  = big_q - sml_q - {31'd0, acc_q};

    unique case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          a_d     = io.A;
          b_d     = io.B;
          flg_d   = {a_nan, b_nan, a_inf, b_inf,
                     a_zero, b_zero, a_sub, b_sub};
          res_d   = '0;
          carry_d = 1'b0;
          stk_d   = 1'b0;
          expo_d  = '0;
          sgn_d   = 1'b0;
          byp_d   = 1'b0;
          aex_d   = 1'b0;
          bex_d   = 1'b0;
          big_d   = {big_h, big_m, {EXT_W{1'b0}}};
          sml_d   = {sml_h, sml_m, {EXT_W{1'b0}}};
          acc_d   = 1'b0;
          rem_d   = diff;
          bsgn_d  = a_big ? fa.sign : fb.sign;
          esub_d  = fa.sign ^ fb.sign;
          bexp_d  = big_ee;
          if (special) begin
            state_d = S_DONE;
          end else if (far) begin
            state_d = S_DONE;
            byp_d   = 1'b1;
            aex_d   = a_big;
            bex_d   = ~a_big;
          end else if (diff == 8'd0) begin
            state_d = S_ADD;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        sml_d = sml_q >> step;
        acc_d = acc_q | (|(sml_q & mask));
        rem_d = rem_q - step;
        if (rem_d == 8'd0) state_d = S_ADD;
      end
      S_ADD: begin
        if (esub_q) begin
          res_d   = dif;
          carry_d = 1'b0;
          // exact cancellation is reported as +0
          sgn_d   = (dif != 32'd0) & bsgn_q;
        end else begin
          {carry_d, res_d} = sum;
          sgn_d   = bsgn_q;
        end
        stk_d   = acc_q;
        expo_d  = bexp_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      big_q   <= '0;
      sml_q   <= '0;
      acc_q   <= 1'b0;
      rem_q   <= '0;
      bsgn_q  <= 1'b0;
      esub_q  <= 1'b0;
      bexp_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      stk_q   <= 1'b0;
      sgn_q   <= 1'b0;
      expo_q  <= '0;
      flg_q   <= '0;
      byp_q   <= 1'b0;
      aex_q   <= 1'b0;
      bex_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      big_q   <= big_d;
      sml_q   <= sml_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      bsgn_q  <= bsgn_d;
      esub_q  <= esub_d;
      bexp_q  <= bexp_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      stk_q   <= stk_d;
      sgn_q   <= sgn_d;
      expo_q  <= expo_d;
      flg_q   <= flg_d;
      byp_q   <= byp_d;
      aex_q   <= aex_d;
      bex_q   <= bex_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign io.in_ready      = (state_q == S_IDLE);
  assign io.out_valid     = (state_q == S_DONE);
  assign io.alignedResult = res_q;
  assign io.carryOut      = carry_q;
  assign io.sticky        = stk_q;
  assign io.exponentOut   = expo_q;
  assign io.alignedSign   = sgn_q;
  assign {io.ANaN, io.BNaN, io.Ainf, io.Binf,
          io.Azero, io.Bzero, io.Asub, io.Bsub}
                          = flg_q;
  assign io.bypassALU     = byp_q;
  assign io.Aex           = aex_q;
  assign io.Bex           = bex_q;
  assign io.A_q           = a_q;
  assign io.B_q           = b_q;

`ifdef FP_ALIGN_STATS_EN
  logic [31:0] ops_q, ops_d;
  logic [31:0] bps_q, bps_d;
  logic [31:0] shc_q, shc_d;
  logic        spc_q, spc_d;
  logic        hs_done;

  always_comb begin
    hs_done = (state_q == S_DONE) & io.out_ready;
    spc_d   = spc_q;
    if (state_q == S_IDLE && io.in_valid)
      spc_d = special | far;
    ops_d = hs_done ? sat_inc(ops_q) : ops_q;
    bps_d = (hs_done & spc_q) ?
            sat_inc(bps_q) : bps_q;
    shc_d = (state_q == S_SHIFT) ?
            sat_inc(shc_q) : shc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q <= '0;
      bps_q <= '0;
      shc_q <= '0;
      spc_q <= 1'b0;
    end else begin
      ops_q <= ops_d;
      bps_q <= bps_d;
      shc_q <= shc_d;
      spc_q <= spc_d;
    end
  end

  assign stat_ops          = ops_q;
  assign stat_bypass       = bps_q;
  assign stat_shift_cycles = shc_q;
`endif

endmodule
